bus_arb_rr: RTL
===============

# bus_arb_rr

Parametrised N-way system bus arbiter. Grants exclusive bus ownership to one of `N_REQ` masters (DMA channels, TDSP, host ports) with selectable round-robin or fixed priority. A mandatory one-cycle turnaround separates owners, and an optional hold-time limit preempts a master that keeps the bus while others wait. It sits between the bus masters and the shared system bus mux/decoder and drives the mux select.

## Interface
- `N_REQ`, 4 — number of requesters; legal range 2..16.
- `MAX_HOLD`, 16 — maximum consecutive grant cycles before preemption; legal range 2..255. Used only with `BUS_ARB_TIMEOUT_EN`.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `breq`  in  N_REQ  bus request per master; bit i belongs to master i.
- `pri_mode`  in  1  0 = round-robin; 1 = fixed priority, with index 0 highest.
- `grant`  out  N_REQ  one-hot bus grant, registered; all zero when no owner.
- `grant_valid`  out  1  OR of `grant`, registered.
- `grant_id`  out  clog2(N_REQ)  index of the current owner, registered; holds its last value when `grant_valid`=0.
- `timeout`  out  1  one-cycle pulse on a preemption.

## Operation
- States:
  - IDLE: no owner.
  - GRANT: owner holds the bus.
  - CLEAR: one-cycle turnaround with all grants low.
- Reset values: state=IDLE, `grant`=0, `grant_valid`=0, `grant_id`=0, `timeout`=0, RR pointer=0, hold counter=0.
- IDLE or CLEAR, `breq`≠0:
  - Select a winner.
  - `grant`<=onehot(winner), `grant_id`<=winner, `grant_valid`<=1.
  - Hold counter<=1. Go to GRANT.
- IDLE or CLEAR, `breq`=0: all outputs stay 0; go to IDLE.
- Winner selection:
  - Round-robin: first set bit of the eligible requests, searching upward from the RR pointer with wrap at N_REQ-1→0.
  - Fixed: lowest-index eligible request.
  - `pri_mode` is sampled only at the selection edge. Changing it while in GRANT has no effect on the current owner.
- Eligible requests: `breq`, except in the CLEAR cycle following a preemption, where the preempted master's bit is masked. If that mask leaves no eligible request, the preempted master is granted again.
- GRANT, `breq[owner]`=1 and no preemption: grant held; hold counter increments, saturating at `MAX_HOLD`.
- GRANT, `breq[owner]`=0 (release):
  - `grant`<=0, `grant_valid`<=0.
  - RR pointer<=(owner+1) mod N_REQ.
  - Go to CLEAR.
- Preemption (GRANT, `BUS_ARB_TIMEOUT_EN` only): when hold counter==`MAX_HOLD` and any other `breq` bit is set:
  - Behaves as a release.
  - `timeout`<=1 for exactly one cycle, coincident with the CLEAR cycle.
- At most one `grant` bit is ever set. `grant` never changes directly from one owner to another; CLEAR always intervenes.
- Requests from non-owners during GRANT are ignored until the next selection edge.
- Reset asserted mid-GRANT: all outputs go to 0 immediately (asynchronous). First possible grant is at the second rising edge after reset deassertion.

## Timing
- Request to grant:
  - 1 cycle from IDLE: `breq` seen high at edge k → `grant` high after edge k.
  - Also 1 cycle from CLEAR.
- Release to grant low: 1 cycle. Owner drops `breq` before edge k → `grant` low after edge k.
- Owner hand-off: release at edge k; CLEAR for cycle k..k+1; new grant after edge k+1. Exactly 1 dead cycle.
- Preemption: the owner holds `grant` for exactly `MAX_HOLD` cycles, then 1 CLEAR cycle with `timeout`=1.
- Hold counter width: clog2(MAX_HOLD+1) bits.
- No combinational path from inputs to outputs.

## Configuration
- `BUS_ARB_TIMEOUT_EN` defined:
  - Hold counter and preemption logic are compiled in.
  - `timeout` behaves as specified.
- `BUS_ARB_TIMEOUT_EN` undefined:
  - Counter and preemption logic are removed; an owner holds the bus until it releases `breq`.
  - `timeout` is tied to 0.
  - `MAX_HOLD` is ignored.

## Test plan
- Reset, then `breq`=4'b0100 held 3 cycles then dropped → `grant`=0100 and `grant_id`=2 one cycle after the request, for 3 cycles; 1 CLEAR cycle; then IDLE with all outputs 0.
- RR mode, `breq`=4'b1111, each owner releases after 2 cycles and re-requests immediately → grant order 0,1,2,3,0, with exactly 1 all-zero cycle between owners.
- Fixed mode, `breq`=4'b1010, master 1 releases → `grant` sequence 0010, 0000, 1000; master 3 is served only after master 1 drops.
- `BUS_ARB_TIMEOUT_EN`, `MAX_HOLD`=4: master 0 holds `breq` permanently, master 2 requests → master 0 granted 4 cycles; CLEAR with `timeout`=1; then `grant`=0100. With only master 0 requesting, no preemption occurs.
- Owner granted, `reset` pulsed mid-grant → `grant`, `grant_valid` and `timeout` go to 0 asynchronously; `grant_id`=0; arbitration resumes from pointer 0.

Source files
------------

// File: rtl/bus_arb_rr.sv
// bus_arb_rr: N-way system bus arbiter (round-robin or fixed priority) that drives the bus mux select.
// Latency: request to grant 1 cycle from IDLE or CLEAR; release to grant low 1 cycle; all outputs registered.
// Backpressure: none; masters keep breq high until granted. BUS_ARB_TIMEOUT_EN adds a hold limit with preemption.
module bus_arb_rr #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         breq,
    input  logic                     pri_mode,
    output logic [N_REQ-1:0]         grant,
    output logic                     grant_valid,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     timeout
);

    localparam int ID_W = $clog2(N_REQ);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    localparam logic [N_REQ-1:0] ONE_N   = N_REQ'(1);
    localparam logic [ID_W-1:0]  ONE_ID  = ID_W'(1);
    localparam logic [ID_W-1:0]  LAST_ID = ID_W'(N_REQ - 1);
    localparam logic [ID_W:0]    N_EXT   = (ID_W + 1)'(N_REQ);

    // Out-of-range parameters are rejected at elaboration time.
    if (N_REQ < 2 || N_REQ > 16 || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_param_check
        $error("bus_arb_rr: N_REQ or MAX_HOLD out of range");
    end

    logic [1:0]         state;
    logic               rst_done;
    logic [ID_W-1:0]    rr_ptr;
    logic [N_REQ-1:0]   owner_mask;
    logic [N_REQ-1:0]   elig;
    logic [N_REQ-1:0]   rot;
    logic [N_REQ-1:0]   srch;
    logic [2*N_REQ-1:0] dbl;
    logic [ID_W-1:0]    first_id;
    logic [ID_W-1:0]    win_id;
    logic [ID_W:0]      rr_sum;
    logic               win_vld;
    logic               sel;
    logic               owner_req;
    logic               release_evt;
    logic               preempt;

    // The current owner is always grant_id; its request bit decides hold vs release.
    assign owner_mask  = ONE_N << grant_id;
    assign owner_req   = (breq & owner_mask) != '0;
    assign sel         = (state != ST_GRANT) && rst_done && win_vld;
    assign release_evt = (state == ST_GRANT) && (!owner_req || preempt);

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int                HOLD_W   = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    logic [HOLD_W-1:0] hold_cnt;
    logic [N_REQ-1:0]  others;

    assign others  = breq & ~owner_mask;
    // A still-requesting owner that has used its full budget is evicted only if someone else is waiting.
    assign preempt = (state == ST_GRANT) && owner_req && (hold_cnt == HOLD_MAX) && (others != '0);

    // timeout is high exactly in the CLEAR cycle after a preemption: mask the evicted master unless it is alone.
    always_comb begin
        elig = breq;
        if (timeout && (others != '0)) begin
            elig = others;
        end
    end

    // Hold counter loads 1 with each new grant, saturates at MAX_HOLD, and the timeout pulse follows preemption.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= preempt;
            if (sel) begin
                hold_cnt <= HOLD_ONE;
            end else if ((state == ST_GRANT) && !release_evt) begin
                if (hold_cnt != HOLD_MAX) begin
                    hold_cnt <= hold_cnt + HOLD_ONE;
                end
            end else begin
                hold_cnt <= '0;
            end
        end
    end
`else
    assign preempt = 1'b0;
    assign timeout = 1'b0;

    // Without the hold limit every request is eligible at a selection edge.
    always_comb begin
        elig = breq;
    end
`endif

    // Winner selection: rotate so the RR pointer sits at bit 0, pick the lowest set bit, un-rotate.
    always_comb begin
        dbl      = {elig, elig} >> rr_ptr;
        rot      = dbl[N_REQ-1:0];
        srch     = pri_mode ? elig : rot;
        win_vld  = |srch;
        first_id = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (srch[i]) begin
                first_id = ID_W'(i);
            end
        end
        rr_sum = {1'b0, rr_ptr} + {1'b0, first_id};
        if (rr_sum >= N_EXT) begin
            rr_sum = rr_sum - N_EXT;
        end
        win_id = pri_mode ? first_id : rr_sum[ID_W-1:0];
    end

    // Arbiter FSM: IDLE/CLEAR select a new owner, GRANT holds until release or preemption.
    // rst_done blocks selection on the first edge after reset so the earliest grant lands on the second edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            rst_done    <= 1'b0;
            rr_ptr      <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
        end else begin
            rst_done <= 1'b1;
            if (sel) begin
                state       <= ST_GRANT;
                grant       <= ONE_N << win_id;
                grant_id    <= win_id;
                grant_valid <= 1'b1;
            end else if (release_evt) begin
                state       <= ST_CLEAR;
                grant       <= '0;
                grant_valid <= 1'b0;
                rr_ptr      <= (grant_id == LAST_ID) ? '0 : grant_id + ONE_ID;
            end else if (state != ST_GRANT) begin
                state       <= ST_IDLE;
                grant       <= '0;
                grant_valid <= 1'b0;
            end
        end
    end

endmodule
